// File: rtl/lt24_led_out_pio.sv
// lt24_led_out_pio: Avalon-MM slave output PIO driving the board LEDs.
//
// Software writes a base LED pattern (DATA). Bits selected in BLINK_EN are
// blanked while the prescaler phase is 1, so status LEDs flash without polling.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   address    - word offset: 0 DATA, 1 BLINK_EN, 2 BLINK_DIV, 3 SET / live out_port
//   chipselect - slave select; only qualifies writes
//   write_n    - active-low write strobe
//   writedata  - write data; bits above each register's width are ignored
//   readdata   - registered, zero-extended read data (latency 1)
//   out_port   - registered LED drive
module lt24_led_out_pio #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DIV_WIDTH  = 24,
  parameter int unsigned DATA_RESET = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] LpDataReset = WIDTH'(DATA_RESET);
  localparam logic [DIV_WIDTH-1:0] LpCntOne = DIV_WIDTH'(1);

  logic [WIDTH-1:0]     r_data;
  logic [WIDTH-1:0]     r_blink_en;
  logic [DIV_WIDTH-1:0] r_blink_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_phase;

  logic                 w_write;
  logic                 w_wr_data;
  logic                 w_wr_en;
  logic                 w_wr_div;
  logic                 w_wr_set;
  logic [31:0]          w_rd_next;
  logic [WIDTH-1:0]     w_out_next;
  logic                 w_unused;

  assign w_write   = chipselect & ~write_n;
  assign w_wr_data = w_write & (address == 2'd0);
  assign w_wr_en   = w_write & (address == 2'd1);
  assign w_wr_div  = w_write & (address == 2'd2);
  assign w_wr_set  = w_write & (address == 2'd3);

  // Upper writedata bits have no destination.
  assign w_unused = ^writedata;

  // Register file.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data      <= LpDataReset;
      r_blink_en  <= '0;
      r_blink_div <= '0;
    end else begin
      if (w_wr_data) r_data <= writedata[WIDTH-1:0];
      if (w_wr_set)  r_data <= r_data | writedata[WIDTH-1:0];
      if (w_wr_en)   r_blink_en <= writedata[WIDTH-1:0];
      if (w_wr_div)  r_blink_div <= writedata[DIV_WIDTH-1:0];
    end
  end

  // Blink prescaler. A BLINK_DIV write restarts the period and wins over the
  // terminal-count reload; a zero divider parks the counter and phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wr_div) begin
      r_cnt   <= writedata[DIV_WIDTH-1:0];
      r_phase <= 1'b0;
    end else if (r_blink_div == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt   <= r_blink_div;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - LpCntOne;
    end
  end

  assign w_out_next = r_data & ~(r_blink_en & {WIDTH{r_phase}});

  // Read mux samples current register contents, so a same-cycle write is
  // seen only on the following read.
  always_comb begin
    w_rd_next = '0;
    unique case (address)
      2'd0: w_rd_next = 32'(r_data);
      2'd1: w_rd_next = 32'(r_blink_en);
      2'd2: w_rd_next = 32'(r_blink_div);
      2'd3: w_rd_next = 32'(out_port);
      default: w_rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= LpDataReset;
      readdata <= '0;
    end else begin
      out_port <= w_out_next;
      readdata <= w_rd_next;
    end
  end

endmodule

// File: doc/lt24_led_out_pio.md
# lt24_led_out_pio

Avalon-MM slave output port that drives the board LEDs (LEDR[9:0]) from the Nios II system. It is the write-side counterpart to the slider input port: software writes a data register whose bits appear on `out_port`. A per-bit hardware blink mode, paced by a programmable prescaler, lets software flash status LEDs without polling. It sits on the system interconnect next to the input PIOs and uses the same 2-bit word address space and read latency of 1.

## Interface
- `WIDTH`, 10, number of output bits (LED count)
- `DIV_WIDTH`, 24, width of the blink prescaler reload register
- `DATA_RESET`, 0, reset value of DATA and of `out_port`
- `clk` in 1 system clock; all logic on rising edge
- `reset_n` in 1 asynchronous, active-low reset
- `address` in 2 word offset within the slave
- `chipselect` in 1 slave select, active high
- `write_n` in 1 write strobe, active low; write = `chipselect & ~write_n`
- `writedata` in 32 write data; bits above the register width ignored
- `readdata` out 32 registered read data, zero-extended
- `out_port` out WIDTH registered LED drive

## Operation
- Register map (word offsets):
  - 0 DATA, R/W, WIDTH bits: base LED pattern
  - 1 BLINK_EN, R/W, WIDTH bits: 1 = bit blinks
  - 2 BLINK_DIV, R/W, DIV_WIDTH bits: prescaler reload; 0 = blink halted
  - 3 SET: write ORs `writedata[WIDTH-1:0]` into DATA; read returns live `out_port`
- Prescaler: down-counter `cnt` (DIV_WIDTH bits) plus 1-bit `phase`
  - BLINK_DIV = 0: `cnt` held 0, `phase` held 0
  - else if `cnt` = 0: `cnt` <= BLINK_DIV, `phase` toggles
  - else `cnt` <= `cnt` - 1
  - one `phase` half-period = BLINK_DIV+1 cycles
- Write to BLINK_DIV: `cnt` <= new value, `phase` <= 0; overrides the terminal-count action in the same cycle
- Output: `out_port` <= DATA & ~(BLINK_EN & {WIDTH{phase}}); blinking bits are dark while `phase` = 1
- Reads have no side effects; `chipselect` is not required for reads
- Reset values: DATA = DATA_RESET, BLINK_EN = 0, BLINK_DIV = 0, `cnt` = 0, `phase` = 0, `out_port` = DATA_RESET, `readdata` = 0
- Reset asserted mid-count or mid-write: all state returns to reset values immediately. The interrupted write is lost.

## Timing
- Write: register updates at the clock edge where the write is sampled (edge N). `out_port` reflects the change at edge N+1.
- Read: `readdata` is loaded every cycle from the `address` mux and is valid one cycle after `address` is presented (read latency 1).
- Simultaneous write and read to the same register: `readdata` returns the old value. The new value is visible on the next read.
- Address 3 read returns `out_port` as registered at that edge. It does not return the next value.
- SET write and a DATA-offset write cannot coincide (single port). SET in the same cycle as a terminal count: both take effect.
- `cnt` wraps only through the reload. No underflow past 0.

## Test plan
- Reset: hold `reset_n`=0, then release → `out_port`=0x000, `readdata`=0; reads of offsets 0–3 all return 0.
- DATA write: write 0x2A5 to offset 0 → `out_port`=0x2A5 one cycle after the write edge; offset 0 read returns 0x2A5. Write 0xFFFFFFFF → DATA = 0x3FF.
- SET: DATA=0x00F, write 0x300 to offset 3 → DATA=0x30F; offset 3 read returns 0x30F.
- Blink: DATA=0x3FF, BLINK_EN=0x001, BLINK_DIV=3 → bit 0 alternates in 4-cycle halves (0x3FF ×4, 0x3FE ×4, …); other bits are constant 1.
- DIV collision: write BLINK_DIV=5 on the cycle `cnt` hits 0 with `phase`=0 → `phase` stays 0 and `cnt`=5. The next toggle occurs 6 cycles later. Then write BLINK_DIV=0 → `out_port`=DATA steadily.
- Reset mid-blink: assert `reset_n` while `phase`=1 → `out_port`=DATA_RESET asynchronously. After release, blinking stays off until BLINK_DIV is rewritten.
